mc_ctrl_ext: RTL
================

Name: mc_ctrl_ext

Overview:
- Parametrised multicycle MIPS control unit: Moore FSM, ALU decoder and PC-enable logic in one block.
- Sits between the instruction register/zero flag and the multicycle datapath muxes and strobes.
- Adds to the base instruction set: addi/andi/ori/slti, bne, j, a memory ready handshake, illegal-instruction trap and a retired-instruction counter.

Parameters:
- ALUCTL_W, 4, alu_control width; 4-bit codes zero-extended into it; must be >=4.
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored (treated as 1).
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- opcode  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- iord  out  1  0 = PC address, 1 = ALUOut address
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- ir_write  out  1  IR load
- pc_en  out  1  PC load
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
- imm_zext  out  1  1 = zero-extend imm, 0 = sign-extend
- shamt_sel  out  1  ALU A from shamt (sll/srl/sra)
- alu_control  out  ALUCTL_W  ALU op
- reg_write  out  1  register file write
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut
- illegal  out  1  sticky trap flag
- retired  out  CNT_W  retired-instruction count
- state_o  out  4  current state for debug

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, BEQ, BNE, IEX, IWB, JUMP, TRAP.
- Default for every output is 0 unless listed for a state.
- Reset: state=FETCH, illegal=0, retired=0. While reset is high, mem_read, mem_write, ir_write, pc_en and reg_write are forced 0.

State outputs and transitions:
- FETCH: mem_read=1, alu_src_b=01, alu add.
  - ir_write and pc_en = mem_ready (handshake); both =1 when MEM_HANDSHAKE=0.
  - Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: alu_src_b=11, add.
  - Next state by opcode: 100011/101011 -> MEMADR; 000000 -> REX; 000100 -> BEQ; 000101 -> BNE; 001000/001100/001101/001010 -> IEX; 000010 -> JUMP; any other -> TRAP.
- MEMADR: alu_src_a=1, alu_src_b=10, add. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1, mem_read=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1. Next: FETCH.
- MEMWR: iord=1, mem_write=1, held until mem_ready, then FETCH.
- REX: alu_src_a=1, alu_control from funct.
  - add 0010, sub 0110, and 0000, or 0001, slt 0111, sllv 0011, srlv 0101, srav 1000.
  - sll 1011, srl 1101, sra 1100, each with shamt_sel=1.
  - Unknown funct -> TRAP; otherwise -> RWB.
- RWB: reg_write=1, reg_dst=1. Next: FETCH.
- BEQ / BNE: alu_src_a=1, sub, pc_src=01.
  - pc_en = zero for BEQ, !zero for BNE.
  - Next: FETCH.
- IEX: alu_src_a=1, alu_src_b=10.
  - addi: add, sign-extend. andi: and, imm_zext=1. ori: or, imm_zext=1. slti: slt, sign-extend.
  - Next: IWB.
- IWB: reg_write=1, reg_dst=0. Next: FETCH.
- JUMP: pc_src=10, pc_en=1. Next: FETCH.
- TRAP: illegal=1; all strobes 0. TRAP is terminal and is left only by reset.

Retired counter:
- retired increments by 1 on every transition into FETCH from MEMWB, MEMWR, RWB, BEQ, BNE, IWB or JUMP.
- Wraps modulo 2^CNT_W.

Boundary conditions:
- Reset asserted in any state (including a memory wait) returns to FETCH immediately. No write strobe is issued after reset.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- opcode/funct are sampled combinationally from the IR; the IR is stable after FETCH.

Decomposition:
- Package mc_ctrl_pkg holds:
  - State enum (4-bit).
  - Opcode and funct localparams.
  - 4-bit ALU code localparams.
  - pc_src and alu_src_b encodings.
- One combinational sub-module mc_alu_dec (funct, alu_op -> alu_control, shamt_sel, funct_valid). FSM, counter and pc_en logic stay in the top.

Test Plan:
- lw, mem_ready low 2 cycles in MEMRD -> states FETCH,DECODE,MEMADR,MEMRD x3,MEMWB,FETCH; reg_write=1 and mem_to_reg=1 only in MEMWB; retired=1.
- R-type funct=000000 (sll) -> REX: alu_control=1011, shamt_sel=1; RWB: reg_dst=1, reg_write=1.
- bne with zero=0 -> pc_en=1, pc_src=01 in BNE; repeat with zero=1 -> pc_en=0; retired increments both times.
- ori -> IEX: alu_control=0001, imm_zext=1, alu_src_b=10; IWB reg_write=1, reg_dst=0.
- opcode 111111 -> TRAP, illegal=1 held for 10 cycles, retired unchanged; reset -> FETCH, illegal=0.
- sw with reset pulsed during MEMWR wait -> mem_write drops same cycle, state_o=FETCH, retired=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the extended multicycle MIPS control unit:
// FSM states, instruction fields, ALU codes and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_BNE    = 4'd9,
        S_IEX    = 4'd10,
        S_IWB    = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    // Operation class requested from the ALU decoder by the FSM.
    typedef enum logic [2:0] {
        AOP_NONE  = 3'd0,
        AOP_ADD   = 3'd1,
        AOP_SUB   = 3'd2,
        AOP_AND   = 3'd3,
        AOP_OR    = 3'd4,
        AOP_SLT   = 3'd5,
        AOP_FUNCT = 3'd6
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLLV = 4'b0011;
    localparam logic [3:0] ALU_SRLV = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRAV = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;
    localparam logic [3:0] ALU_SRL  = 4'b1101;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mc_ctrl_ext_alu_dec.sv
// ALU decoder: maps the FSM's operation class (and funct for R-type)
// to a 4-bit ALU code, the shift-amount select and a funct legality flag.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    input  alu_op_t    alu_op,
    output logic [3:0] alu_code,
    output logic       shamt_sel,
    output logic       funct_valid
);

    logic [3:0] f_code;
    logic       f_shamt;

    always_comb begin
        f_code      = ALU_AND;
        f_shamt     = 1'b0;
        funct_valid = 1'b1;
        case (funct)
            F_ADD:   f_code = ALU_ADD;
            F_SUB:   f_code = ALU_SUB;
            F_AND:   f_code = ALU_AND;
            F_OR:    f_code = ALU_OR;
            F_SLT:   f_code = ALU_SLT;
            F_SLLV:  f_code = ALU_SLLV;
            F_SRLV:  f_code = ALU_SRLV;
            F_SRAV:  f_code = ALU_SRAV;
            F_SLL:   begin f_code = ALU_SLL; f_shamt = 1'b1; end
            F_SRL:   begin f_code = ALU_SRL; f_shamt = 1'b1; end
            F_SRA:   begin f_code = ALU_SRA; f_shamt = 1'b1; end
            default: funct_valid = 1'b0;
        endcase
    end

    always_comb begin
        alu_code  = ALU_AND;
        shamt_sel = 1'b0;
        case (alu_op)
            AOP_ADD:   alu_code = ALU_ADD;
            AOP_SUB:   alu_code = ALU_SUB;
            AOP_AND:   alu_code = ALU_AND;
            AOP_OR:    alu_code = ALU_OR;
            AOP_SLT:   alu_code = ALU_SLT;
            AOP_FUNCT: begin alu_code = f_code; shamt_sel = f_shamt; end
            default:   alu_code = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_ext.sv
// Multicycle MIPS control unit: Moore FSM with memory handshake, illegal
// instruction trap, retired-instruction counter and PC-enable logic.
module mc_ctrl_ext
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTL_W      = 4,
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                pc_en,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                imm_zext,
    output logic                shamt_sel,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired,
    output logic [3:0]          state_o
);

    state_t     state, next_state;
    alu_op_t    alu_op;
    logic [3:0] alu_code;
    logic       funct_valid;
    logic       mem_rdy;

    // Without the handshake every memory access completes in one cycle.
    assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    mc_alu_dec u_alu_dec (
        .funct       (funct),
        .alu_op      (alu_op),
        .alu_code    (alu_code),
        .shamt_sel   (shamt_sel),
        .funct_valid (funct_valid)
    );

    assign alu_control = ALUCTL_W'(alu_code);
    assign state_o     = state;

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (mem_rdy) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                      next_state = S_MEMADR;
                    OP_RTYPE:                          next_state = S_REX;
                    OP_BEQ:                            next_state = S_BEQ;
                    OP_BNE:                            next_state = S_BNE;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = S_IEX;
                    OP_J:                              next_state = S_JUMP;
                    default:                           next_state = S_TRAP;
                endcase
            end
            S_MEMADR: next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_rdy) next_state = S_MEMWB;
            S_MEMWR:  if (mem_rdy) next_state = S_FETCH;
            S_REX:    next_state = funct_valid ? S_RWB : S_TRAP;
            S_IEX:    next_state = S_IWB;
            S_MEMWB, S_RWB, S_BEQ, S_BNE, S_IWB, S_JUMP: next_state = S_FETCH;
            S_TRAP:   next_state = S_TRAP;
            default:  next_state = S_FETCH;
        endcase
    end

    always_comb begin
        alu_op = AOP_NONE;
        case (state)
            S_FETCH, S_DECODE, S_MEMADR: alu_op = AOP_ADD;
            S_BEQ, S_BNE:                alu_op = AOP_SUB;
            S_REX:                       alu_op = AOP_FUNCT;
            S_IEX: begin
                case (opcode)
                    OP_ANDI: alu_op = AOP_AND;
                    OP_ORI:  alu_op = AOP_OR;
                    OP_SLTI: alu_op = AOP_SLT;
                    default: alu_op = AOP_ADD;
                endcase
            end
            default: alu_op = AOP_NONE;
        endcase
    end

    always_comb begin
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        imm_zext   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_rdy;
                pc_en     = mem_rdy;
            end
            S_DECODE: alu_src_b = SRCB_IMM_SH;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_REX:   alu_src_a = 1'b1;
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BEQ, S_BNE: begin
                alu_src_a = 1'b1;
                pc_src    = PCSRC_ALUOUT;
                pc_en     = (state == S_BEQ) ? zero : !zero;
            end
            S_IEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                imm_zext  = (opcode == OP_ANDI) || (opcode == OP_ORI);
            end
            S_IWB:   reg_write = 1'b1;
            S_JUMP: begin
                pc_src = PCSRC_JUMP;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
        // State is already FETCH during reset; keep every side effect off.
        if (reset) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_en     = 1'b0;
            reg_write = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state <= next_state;
            if (next_state == S_TRAP)
                illegal <= 1'b1;
            // Only completing states ever fall back to FETCH.
            if (next_state == S_FETCH && state != S_FETCH)
                retired <= retired + CNT_W'(1);
        end
    end

endmodule
